// File: rtl/cic_decim_ctrl_if.sv
// Sample handshake and datapath control bundle between the CIC controller and its filter.
// Latency: wires only.
// Backpressure: out_ready low stalls the controller, which drops in_ready and comb_en.
interface cic_decim_ctrl_if #(
    parameter int N_STAGES = 3
);
    logic                in_valid;
    logic                in_ready;
    logic                integ_en;
    logic                integ_clr;
    logic [N_STAGES-1:0] comb_en;
    logic                out_valid;
    logic                out_ready;
    logic [N_STAGES-1:0] ovf_in;

    // controller side
    modport master (
        input  in_valid, out_ready, ovf_in,
        output in_ready, integ_en, integ_clr, comb_en, out_valid
    );

    // datapath / environment side
    modport slave (
        output in_valid, out_ready, ovf_in,
        input  in_ready, integ_en, integ_clr, comb_en, out_valid
    );
endinterface

// File: rtl/cic_decim_ctrl.sv
// CIC decimator sequencer: integrator gating, modulo-R phase count, comb token pipe, status.
// Latency: the R-th accept at edge t raises comb_en[k] during t+1+k and out_valid from t+1+N_STAGES.
// Backpressure: out_valid & ~out_ready freezes the token pipe and deasserts in_ready and comb_en.
module cic_decim_ctrl #(
    parameter int N_STAGES = 3,
    parameter int R_MAX    = 16,
    parameter int R_W      = 5,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [R_W-1:0]       cfg_ratio,
    input  logic                 start,
    input  logic                 stop,
    cic_decim_ctrl_if.master     bus,
    output logic                 ovf_flag,
    output logic                 busy,
    output logic [CNT_W-1:0]     out_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [R_W-1:0] RMAX_V = R_W'(R_MAX);

    state_t              state;
    state_t              state_nxt;
    logic [R_W-1:0]      r_eff;
    logic [R_W-1:0]      phase;
    logic [R_W-1:0]      ratio_clamped;
    logic [N_STAGES:0]   tok;
    logic                stall;
    logic                accept;
    logic                wrap;
    logic                handshake;

    always_comb begin
        ratio_clamped = cfg_ratio;
        if (cfg_ratio == '0) begin
            ratio_clamped = R_W'(1);
        end else if (cfg_ratio > RMAX_V) begin
            ratio_clamped = RMAX_V;
        end
    end

    // tok[N_STAGES] is the output-valid stage; a held output freezes everything behind it
    assign stall        = tok[N_STAGES] & ~bus.out_ready;
    assign bus.in_ready = (state == S_RUN) & ~stall;
    assign accept       = bus.in_valid & bus.in_ready;
    assign wrap         = accept & (phase == (r_eff - R_W'(1)));
    assign handshake    = tok[N_STAGES] & bus.out_ready;

    assign bus.integ_en  = accept;
    assign bus.integ_clr = (state == S_CLEAR);
    assign bus.comb_en   = tok[N_STAGES-1:0] & {N_STAGES{~stall}};
    assign bus.out_valid = tok[N_STAGES];
    assign busy          = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN:   if (stop) state_nxt = S_DRAIN;
            S_DRAIN: if (tok == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            r_eff     <= R_W'(1);
            phase     <= '0;
            tok       <= '0;
            ovf_flag  <= 1'b0;
            out_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                r_eff     <= ratio_clamped;
                phase     <= '0;
                ovf_flag  <= 1'b0;
                out_count <= '0;
            end else begin
                if (accept) begin
                    phase <= wrap ? '0 : phase + R_W'(1);
                end
                if ((state == S_RUN || state == S_DRAIN) && (|bus.ovf_in)) begin
                    ovf_flag <= 1'b1;
                end
                if (handshake) begin
                    out_count <= out_count + CNT_W'(1);
                end
            end
            if (!stall) begin
                tok <= {tok[N_STAGES-1:0], wrap};
            end
        end
    end

endmodule
